cpu: RTL and testbench

- Multi-cycle 16-bit processor with eight general registers R0..R7, an A/G accumulator pair and an add/sub ALU.
- Instructions are fetched one word at a time from the din port under a run/done handshake. The bench's instruction driver (vip) provides those words.
- Supports mv, mvi (immediate taken from the next din word), add and sub.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cpu_alu.sv | 16 +
 rtl/cpu.sv | 121 ++++++++++++
 tb/tb_cpu.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the multi-cycle 16-bit cpu.
// Imported by the top level and the ALU.
package cpu_pkg;

    localparam int DW = 16;
    localparam int IW = 9;
    localparam int NREG = 8;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    function automatic logic [2:0] opcode_of(input logic [IW-1:0] insn);
        return insn[IW-1 -: 3];
    endfunction

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational add/subtract unit; results wrap modulo 2^DW.
// No flags are produced.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          sub_sel,
    output logic [DW-1:0] y
);

    always_comb begin
        y = sub_sel ? (a - b) : (a + b);
    end

endmodule

// File: rtl/cpu.sv
// Multi-cycle 16-bit processor: R0..R7, A/G accumulator pair, add/sub ALU.
// Instruction words and mvi immediates arrive on din under run/done.
module cpu
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic [DW-1:0]     din,
    input  logic              run,
    output logic              done,
    output logic [DW-1:0]     bus,
    output logic [NREG*DW-1:0] regs
);

    state_t        state;
    logic [IW-1:0] ir;
    logic [DW-1:0] a;
    logic [DW-1:0] g;
    logic [DW-1:0] r [NREG];
    logic          done_q;

    logic [2:0]    op;
    logic [2:0]    rx;
    logic [2:0]    ry;
    logic          is_mv;
    logic          is_mvi;
    logic          is_alu;
    logic          fetch_alu;
    logic [DW-1:0] bus_v;
    logic [DW-1:0] alu_y;

    assign op     = opcode_of(ir);
    assign rx     = ir[5:3];
    assign ry     = ir[2:0];
    assign is_mv  = (op == OP_MV);
    assign is_mvi = (op == OP_MVI);
    assign is_alu = is_alu_op(op);

    // Decided at fetch so done can be registered into the final cycle
    assign fetch_alu = is_alu_op(opcode_of(din[IW-1:0]));

    always_comb begin
        bus_v = '0;
        case (state)
            T1: begin
                unique case (1'b1)
                    is_mv:   bus_v = r[ry];
                    is_mvi:  bus_v = din;
                    is_alu:  bus_v = r[rx];
                    default: bus_v = '0;
                endcase
            end
            T2:      bus_v = r[ry];
            T3:      bus_v = g;
            default: bus_v = '0;
        endcase
    end

    cpu_alu u_alu (
        .a       (a),
        .b       (bus_v),
        .sub_sel (op == OP_SUB),
        .y       (alu_y)
    );

    always_ff @(posedge clock) begin
        if (resetn) begin
            state  <= T0;
            ir     <= '0;
            a      <= '0;
            g      <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                T0: begin
                    if (run) begin
                        ir     <= din[IW-1:0];
                        state  <= T1;
                        done_q <= !fetch_alu;
                    end
                end
                T1: begin
                    unique case (1'b1)
                        is_mv, is_mvi: begin
                            r[rx] <= bus_v;
                            state <= T0;
                        end
                        is_alu: begin
                            a     <= bus_v;
                            state <= T2;
                        end
                        default: state <= T0;
                    endcase
                end
                T2: begin
                    g      <= alu_y;
                    state  <= T3;
                    done_q <= 1'b1;
                end
                T3: begin
                    r[rx] <= g;
                    state <= T0;
                end
                default: state <= T0;
            endcase
        end
    end

    // Reset forces both observation outputs low in the same cycle
    assign done = done_q & ~resetn;
    assign bus  = resetn ? '0 : bus_v;

    for (genvar i = 0; i < NREG; i++) begin : g_regs
        assign regs[i*DW +: DW] = r[i];
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: a reference model pushes expected
// register/bus/latency results to a queue, popped when done pulses.
module tb_cpu;
    import cpu_pkg::*;

    logic         clock = 1'b0;
    logic         resetn;
    logic         run;
    logic [15:0]  din;
    logic         done;
    logic [15:0]  bus;
    logic [127:0] regs;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [127:0] regs;
        logic [15:0]  bus;
        logic         chk_bus;
        int           lat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m[8];

    cpu dut (
        .clock  (clock),
        .resetn (resetn),
        .din    (din),
        .run    (run),
        .done   (done),
        .bus    (bus),
        .regs   (regs)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] model_regs();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = m[i];
        return v;
    endfunction

    function automatic logic [15:0] enc(input logic [2:0] op,
                                        input logic [2:0] rx,
                                        input logic [2:0] ry);
        return {7'b0, op, rx, ry};
    endfunction

    task automatic model_push(input logic [2:0] op, input logic [2:0] rx,
                              input logic [2:0] ry, input logic [15:0] imm);
        exp_t e;
        logic [15:0] v;
        e.chk_bus = 1'b1;
        e.lat = 2;
        e.bus = '0;
        case (op)
            3'b000: begin v = m[ry]; m[rx] = v; e.bus = v; end
            3'b001: begin m[rx] = imm; e.bus = imm; end
            3'b010: begin v = m[rx] + m[ry]; m[rx] = v; e.bus = v; e.lat = 4; end
            3'b011: begin v = m[rx] - m[ry]; m[rx] = v; e.bus = v; e.lat = 4; end
            default: e.chk_bus = 1'b0;
        endcase
        e.regs = model_regs();
        sb.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m[i] = '0;
        sb.delete();
    endtask

    // Entered and left at posedge+1 with the cpu in T0.
    task automatic issue(input logic [2:0] op, input logic [2:0] rx,
                         input logic [2:0] ry, input logic [15:0] imm);
        exp_t e;
        int cyc;
        logic seen;
        model_push(op, rx, ry, imm);
        din = enc(op, rx, ry);
        run = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 8) begin
            @(negedge clock);
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clock);
                #1;
                run = 1'b0;
                din = imm;
                cyc++;
            end
        end
        e = sb.pop_front();
        n_checks++;
        if (!seen || cyc !== e.lat - 1) begin
            n_fail++;
            $display("FAIL latency op=%b rx=%0d ry=%0d: done at cycle %0d, expected %0d",
                     op, rx, ry, seen ? cyc : -1, e.lat - 1);
        end
        if (seen && e.chk_bus) begin
            n_checks++;
            if (bus !== e.bus) begin
                n_fail++;
                $display("FAIL bus op=%b: got %h expected %h", op, bus, e.bus);
            end
        end
        @(posedge clock);
        #1;
        run = 1'b0;
        din = '0;
        n_checks++;
        if (regs !== e.regs) begin
            n_fail++;
            $display("FAIL regs op=%b rx=%0d ry=%0d: got %h expected %h",
                     op, rx, ry, regs, e.regs);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width op=%b: got %b expected 0", op, done);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        run = 1'b0;
        din = '0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (regs !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h expected 0", regs);
        end
        n_checks++;
        if (done !== 1'b0 || bus !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got done=%b bus=%h expected 0/0000", done, bus);
        end
        resetn = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_out: got done=%b bus=%h expected 0/0000", done, bus);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_mvi();
        issue(OP_MVI, R3, R0, 16'h0003);
        n_checks++;
        if (regs !== {64'h0, 16'h0003, 48'h0}) begin
            n_fail++;
            $display("FAIL mvi_r3: got %h expected R3=0003 only", regs);
        end
    endtask

    task automatic test_sub_self();
        for (int i = 0; i < 8; i++) begin
            issue(OP_MVI, 3'(i), R0, 16'(i));
            issue(OP_SUB, 3'(i), 3'(i), 16'h0);
        end
    endtask

    task automatic test_sub_chain();
        logic [15:0] fin;
        for (int d = 0; d < 8; d++) begin
            for (int i = 0; i < 8; i++) issue(OP_MVI, 3'(i), R0, 16'(i));
            issue(OP_MVI, 3'(d), R0, 16'h0020);
            for (int s = 0; s < 8; s++)
                if (s != d) issue(OP_SUB, 3'(d), 3'(s), 16'h0);
            fin = regs[d*16 +: 16];
            n_checks++;
            if (fin !== 16'(32 - (28 - d))) begin
                n_fail++;
                $display("FAIL chain_final R%0d: got %h expected %h", d, fin,
                         16'(32 - (28 - d)));
            end
        end
    endtask

    task automatic test_wrap();
        issue(OP_MVI, R1, R0, 16'h0000);
        issue(OP_MVI, R2, R0, 16'h0002);
        issue(OP_SUB, R1, R2, 16'h0);
        n_checks++;
        if (regs[31:16] !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL wrap_sub: got %h expected fffe", regs[31:16]);
        end
        issue(OP_MVI, R3, R0, 16'h8001);
        issue(OP_ADD, R3, R3, 16'h0);
        n_checks++;
        if (regs[63:48] !== 16'h0002) begin
            n_fail++;
            $display("FAIL wrap_add: got %h expected 0002", regs[63:48]);
        end
    endtask

    task automatic test_mv_nop();
        issue(OP_MVI, R4, R0, 16'h0004);
        issue(OP_MV, R5, R4, 16'h0);
        n_checks++;
        if (regs[95:80] !== 16'h0004 || regs[79:64] !== 16'h0004) begin
            n_fail++;
            $display("FAIL mv_r5: got R5=%h R4=%h expected 0004/0004",
                     regs[95:80], regs[79:64]);
        end
        issue(3'b111, R2, R3, 16'h0);
        issue(3'b100, R6, R1, 16'h0);
    endtask

    task automatic test_reset_mid();
        issue(OP_MVI, R1, R0, 16'h0009);
        issue(OP_MVI, R2, R0, 16'h0004);
        din = enc(OP_SUB, R1, R2);
        run = 1'b1;
        @(posedge clock);
        #1;
        run = 1'b0;
        din = '0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0 || bus !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got done=%b bus=%h expected 0/0000", done, bus);
        end
        @(posedge clock);
        #1;
        resetn = 1'b0;
        model_clear();
        n_checks++;
        if (regs !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_regs: got %h expected 0", regs);
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_done: got %b expected 0", done);
        end
        @(posedge clock);
        #1;
        issue(OP_MVI, R6, R0, 16'h0066);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[7] = '{OP_MVI, OP_MVI, OP_ADD, OP_MV, OP_SUB, 3'b110, OP_MVI};
        logic [2:0]  rxs[7] = '{R0, R1, R0, R2, R2, R3, R7};
        logic [2:0]  rys[7] = '{R0, R0, R1, R0, R1, R4, R0};
        logic [15:0] imms[7] = '{16'h0011, 16'h0022, 0, 0, 0, 0, 16'hBEEF};
        logic [15:0] words[$];
        logic        dexp[$];
        exp_t        e;
        logic        was_done;
        for (int k = 0; k < 7; k++) begin
            model_push(ops[k], rxs[k], rys[k], imms[k]);
            words.push_back(enc(ops[k], rxs[k], rys[k]));
            dexp.push_back(1'b0);
            for (int c = 1; c < sb[$].lat; c++) begin
                words.push_back(ops[k] == OP_MVI ? imms[k] : 16'h0);
                dexp.push_back(c == sb[$].lat - 1);
            end
        end
        run = 1'b1;
        for (int k = 0; k < words.size(); k++) begin
            din = words[k];
            @(negedge clock);
            was_done = done;
            n_checks++;
            if (done !== dexp[k]) begin
                n_fail++;
                $display("FAIL b2b_done cycle %0d: got %b expected %b", k, done, dexp[k]);
            end
            @(posedge clock);
            #1;
            if (dexp[k] && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (regs !== e.regs) begin
                    n_fail++;
                    $display("FAIL b2b_regs cycle %0d (done=%b): got %h expected %h",
                             k, was_done, regs, e.regs);
                end
            end
        end
        run = 1'b0;
        din = '0;
        n_checks++;
        if (regs[127:112] !== 16'hBEEF || regs[15:0] !== 16'h0033) begin
            n_fail++;
            $display("FAIL b2b_final: got R7=%h R0=%h expected beef/0033",
                     regs[127:112], regs[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_sub_self();
        test_sub_chain();
        test_wrap();
        test_mv_nop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
